md_unit: RTL
============

# md_unit

Iterative multiply/divide unit with HI/LO registers for the MIPS core. It sits directly downstream of the GRF read ports, beside the ALU, and consumes the same rs/rt operands. It accepts mult/multu/div/divu as a multi-cycle operation and signals busy so the controller can stall. It also serves mthi/mtlo writes and drives the mfhi/mflo read data.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu (legal range 1..31).
- DIV_CYCLES, default 10: busy cycles for div/divu (legal range 1..31).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low. Asserted when 0.
- start, input, 1: launch the operation selected by op. Sampled at posedge.
- op, input, 2: 00 mult, 01 multu, 10 div, 11 divu.
- A, input, 32: rs operand (multiplicand or dividend).
- B, input, 32: rt operand (multiplier or divisor).
- mthi, input, 1: write wd to HI.
- mtlo, input, 1: write wd to LO.
- wd, input, 32: data for mthi/mtlo.
- busy, output, 1: operation in flight.
- done, output, 1: one-cycle pulse after results commit.
- hi, output, 32: committed HI.
- lo, output, 32: committed LO.
- div0, output, 1: sticky divide-by-zero flag. Present only with MD_DIV0_TRAP_EN.

## Operation
- Reset state: state IDLE; hi = lo = 0; busy = 0; done = 0; div0 = 0; counter = 0.
- The FSM has two states, IDLE and BUSY.
- IDLE with start = 1:
  - Latch A, B and op.
  - Load the counter with MULT_CYCLES or DIV_CYCLES, according to op.
  - Go to BUSY.
- BUSY:
  - Decrement the counter each cycle.
  - When counter = 1, write the result to hi/lo at that edge and return to IDLE.
- Arithmetic:
  - mult: 64-bit signed product. hi = [63:32], lo = [31:0].
  - multu: 64-bit unsigned product, split the same way.
  - div: signed. lo = quotient, truncated toward zero. hi = remainder, with the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - divu: unsigned. lo = quotient, hi = remainder.
- Divide by zero: behaviour is set by Configuration.
- Operand capture: operands are latched at start, so later changes on A/B have no effect on an operation in flight.
- mthi/mtlo in IDLE (without start):
  - Write wd at the edge.
  - Both asserted writes wd to both registers.
- Priority rules:
  - start and mthi/mtlo in the same IDLE cycle: start wins and the mt write is discarded.
  - start, mthi and mtlo are all ignored while busy = 1. The controller must stall; the unit neither queues nor drops anything silently beyond this rule.
- Unknown conditions: none, since op is fully decoded.

## Timing
- Edge-numbered sequence for one operation:
  - start sampled at edge E0.
  - busy = 1 from just after E0 through the cycle ending at edge E0+N, where N is the selected cycle count.
  - hi/lo update at E0+N.
  - busy falls at E0+N.
  - done = 1 for the cycle following E0+N.
- hi/lo keep their old values for the whole BUSY period. An mfhi during a stall therefore reads stale data, and the controller must not issue it.
- A new start is accepted at E0+N+1 at the earliest (the first IDLE cycle). Back-to-back throughput is one operation per N+1 cycles.
- mthi/mtlo latency: one edge. hi/lo show the new value after the sampling edge.
- Reset mid-operation: immediate, asynchronous return to IDLE. hi/lo clear to 0, busy and done drop, and the partial result is discarded.
- done never overlaps busy.

## Configuration
- Macro: MD_DIV0_TRAP_EN.
- Defined:
  - div/divu with B = 0 still runs the full DIV_CYCLES.
  - hi/lo are left unchanged.
  - div0 sets to 1 at the commit edge and stays set until reset.
  - done still pulses.
- Undefined:
  - The div0 port and its logic are absent.
  - B = 0 commits lo = 0xFFFFFFFF and hi = A, for both signed and unsigned.

## Test plan
- Reset, then mult with A = 0xFFFFFFFF, B = 2 -> busy for exactly 5 cycles; hi = 0xFFFFFFFF, lo = 0xFFFFFFFE; done pulses one cycle.
- multu with A = 0xFFFFFFFF, B = 2 -> hi = 0x00000001, lo = 0xFFFFFFFE. div with A = 0xFFFFFFF9, B = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF after 10 cycles.
- div with 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0. divu with 7/2 -> lo = 3, hi = 1.
- mthi with wd = 0x12345678 in IDLE -> hi updates next edge. start and mtlo in the same cycle -> lo is overwritten only by the result. start and mthi asserted during busy -> ignored, and the original result commits.
- divu with B = 0 -> with MD_DIV0_TRAP_EN: hi/lo unchanged and div0 = 1. Without it: lo = 0xFFFFFFFF, hi = A.
- Assert reset (0) at cycle 3 of a div -> busy = 0, hi = lo = 0 immediately. After release, a new mult runs with full latency.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit with HI/LO registers.
// Accepts mult/multu/div/divu as a fixed-latency operation (busy stalls the
// controller), serves mthi/mtlo writes and exposes the committed HI/LO.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   start, op       launch op (00 mult, 01 multu, 10 div, 11 divu)
//   A, B            rs / rt operands, latched at start
//   mthi, mtlo, wd  direct HI/LO writes in IDLE
//   busy, done      operation in flight / one-cycle pulse after commit
//   hi, lo          committed HI/LO
//   div0            sticky divide-by-zero flag (MD_DIV0_TRAP_EN only)
//
// Optional feature macro: MD_DIV0_TRAP_EN (divide-by-zero trap flag).
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
`ifdef MD_DIV0_TRAP_EN
    output logic [31:0] lo,
    output logic        div0
`else
    output logic [31:0] lo
`endif
);

    localparam int unsigned CW = 5;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [31:0]     hi_d, lo_d;
    logic            busy_d, done_d;
`ifdef MD_DIV0_TRAP_EN
    logic            div0_d;
`endif

    // Arithmetic on the latched operands
    logic signed [63:0] sa, sb;
    logic [63:0]        prod_s, prod_u;
    logic               b_zero;
    logic [31:0]        b_den, a_mag, b_mag, mag_den;
    logic [31:0]        sq, sr, uq, ur, q_s, r_s;
    logic [31:0]        res_hi, res_lo;

    always_comb begin
        sa      = {{32{a_q[31]}}, a_q};
        sb      = {{32{b_q[31]}}, b_q};
        prod_s  = 64'(sa * sb);
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        b_zero  = (b_q == 32'd0);
        // Divisor forced to 1 on zero so the divider never produces X
        b_den   = b_zero ? 32'd1 : b_q;
        uq      = a_q / b_den;
        ur      = a_q % b_den;
        // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0
        a_mag   = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag   = b_q[31] ? (~b_q + 32'd1) : b_q;
        mag_den = b_zero ? 32'd1 : b_mag;
        sq      = a_mag / mag_den;
        sr      = a_mag % mag_den;
        q_s     = (a_q[31] ^ b_q[31]) ? (~sq + 32'd1) : sq;
        r_s     = a_q[31] ? (~sr + 32'd1) : sr;
        unique case (op_q)
            2'b00:   begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            2'b01:   begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            2'b10:   begin res_hi = r_s;           res_lo = q_s;          end
            default: begin res_hi = ur;            res_lo = uq;           end
        endcase
`ifndef MD_DIV0_TRAP_EN
        if (op_q[1] && b_zero) begin
            res_hi = a_q;
            res_lo = 32'hFFFF_FFFF;
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef MD_DIV0_TRAP_EN
            div0  <= 1'b0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            hi    <= hi_d;
            lo    <= lo_d;
            busy  <= busy_d;
            done  <= done_d;
`ifdef MD_DIV0_TRAP_EN
            div0  <= div0_d;
`endif
        end
    end

    // Next-state and register-update logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi;
        lo_d    = lo;
        busy_d  = busy;
        done_d  = 1'b0;
`ifdef MD_DIV0_TRAP_EN
        div0_d  = div0;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op;
                    cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d = BUSY;
                    busy_d  = 1'b1;
                end else begin
                    if (mthi) hi_d = wd;
                    if (mtlo) lo_d = wd;
                end
            end
            default: begin
                if (cnt == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
`ifdef MD_DIV0_TRAP_EN
                    if (op_q[1] && b_zero) begin
                        div0_d = 1'b1;
                    end else begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
`else
                    hi_d = res_hi;
                    lo_d = res_lo;
`endif
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
        endcase
    end

endmodule
